// File: rtl/mic_filter_pkg.sv
// Shared definitions for the microphone filter: control word layout, FSM states,
// and the saturation range test used by the gain stage.
package mic_filter_pkg;

    localparam int CNTL_EN     = 0;
    localparam int CNTL_CLR    = 1;
    localparam int CNTL_L_LSB  = 2;
    localparam int CNTL_L_W    = 3;
    localparam int CNTL_G_LSB  = 5;
    localparam int CNTL_G_W    = 4;
    localparam int CNTL_MUTE   = 9;
    localparam int CNTL_USED_W = 10;

    typedef enum logic {
        FLUSH,
        RUN
    } state_t;

    // True when v is representable as a w-bit two's complement number.
    function automatic logic fits_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mic_filter_if.sv
// Sample stream bundle: upstream valid/ready input and downstream valid/ready output.
interface mic_filter_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mic_filter_sat_shift.sv
// Gain stage: left-shifts the window average by G and saturates back to the
// sample width, flagging when saturation changed the value.
module mic_filter_sat_shift
    import mic_filter_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] avg,
    input  logic [CNTL_G_W-1:0]      gain,
    output logic signed [DATA_W-1:0] result,
    output logic                     clip
);
    localparam int WIDE_W = DATA_W + 15;
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [WIDE_W-1:0] wide;

    assign wide   = $signed({{15{avg[DATA_W-1]}}, avg}) <<< gain;
    assign clip   = !fits_signed(64'(wide), DATA_W);
    assign result = clip ? (wide[WIDE_W-1] ? SAT_MIN : SAT_MAX) : wide[DATA_W-1:0];
endmodule

// File: rtl/mic_filter_core.sv
// Streaming moving-average filter with gain, saturation, mute and bypass.
//   state | meaning
//   FLUSH | one or more cycles clearing history/sum/wr_ptr; input stalled
//   RUN   | accepting samples, one per clock
module mic_filter_core
    import mic_filter_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_LOG2 = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      cntl,
    mic_filter_if.slave      bus,
    output logic [CNT_W-1:0] clip_count,
    output logic             flushing
);
    localparam int DEPTH = 2 ** MAX_LOG2;
    localparam int SUM_W = DATA_W + MAX_LOG2;

    state_t                   state;
    logic [CNTL_USED_W-1:0]   cntl_q;
    logic                     en_prev;
    logic [CNTL_L_W-1:0]      l_prev;
    logic [CNTL_L_W-1:0]      l_raw;
    logic [CNTL_L_W-1:0]      l_eff;
    logic signed [DATA_W-1:0] history [DEPTH];
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_n;
    logic [MAX_LOG2-1:0]      wr_ptr;
    logic [MAX_LOG2-1:0]      rd_ptr;
    logic [MAX_LOG2:0]        win;
    logic signed [DATA_W-1:0] avg;
    logic signed [DATA_W-1:0] sat_out;
    logic signed [DATA_W-1:0] result;
    logic                     clip;
    logic                     accept;
    logic                     en;
    logic                     clr;
    logic                     mute;
    logic                     restart;
    logic                     unused_cntl;

    assign unused_cntl = ^cntl[31:CNTL_USED_W];

    assign en    = cntl_q[CNTL_EN];
    assign clr   = cntl_q[CNTL_CLR];
    assign mute  = cntl_q[CNTL_MUTE];
    assign l_raw = cntl_q[CNTL_L_LSB +: CNTL_L_W];
    assign l_eff = (int'(l_raw) > MAX_LOG2) ? CNTL_L_W'(MAX_LOG2) : l_raw;

    // Full-depth window wraps to wr_ptr itself: the slot about to be overwritten.
    assign win    = (MAX_LOG2+1)'(1) << l_eff;
    assign rd_ptr = MAX_LOG2'({1'b0, wr_ptr} - win);
    assign sum_n  = sum + SUM_W'(bus.in_data) - SUM_W'(history[rd_ptr]);
    assign avg    = DATA_W'(sum_n >>> l_eff);

    mic_filter_sat_shift #(.DATA_W(DATA_W)) u_sat (
        .avg    (avg),
        .gain   (cntl_q[CNTL_G_LSB +: CNTL_G_W]),
        .result (sat_out),
        .clip   (clip)
    );

    assign result       = mute ? '0 : (en ? sat_out : bus.in_data);
    assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign restart      = clr || (l_eff != l_prev) || (en && !en_prev);
    assign flushing     = (state == FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= FLUSH;
            cntl_q        <= '0;
            en_prev       <= 1'b0;
            l_prev        <= '0;
            sum           <= '0;
            wr_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            clip_count    <= '0;
            for (int i = 0; i < DEPTH; i++) history[i] <= '0;
        end else begin
            cntl_q  <= cntl[CNTL_USED_W-1:0];
            en_prev <= en;
            l_prev  <= l_eff;

            case (state)
                FLUSH: begin
                    for (int i = 0; i < DEPTH; i++) history[i] <= '0;
                    sum    <= '0;
                    wr_ptr <= '0;
                    if (!clr) state <= RUN;
                end
                RUN: begin
                    if (restart) state <= FLUSH;
                    if (accept && en) begin
                        history[wr_ptr] <= bus.in_data;
                        sum             <= sum_n;
                        wr_ptr          <= wr_ptr + MAX_LOG2'(1);
                    end
                end
                default: state <= FLUSH;
            endcase

            // Output register is independent of FLUSH so a pending sample survives it.
            if (accept) begin
                bus.out_data  <= result;
                bus.out_valid <= 1'b1;
                if (en && clip && !(&clip_count)) clip_count <= clip_count + CNT_W'(1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mic_filter_core.sv
// Scoreboard bench for mic_filter_core: a window-average reference model fills
// an expectation queue on each accepted sample; a monitor checks each output.
module tb_mic_filter_core;
    localparam int DW     = 16;
    localparam int CW     = 8;
    localparam int CLIP_M = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   cntl = '0;
    logic [CW-1:0] clip_count;
    logic          flushing;

    mic_filter_if #(.DATA_W(DW)) bus ();

    mic_filter_core #(.DATA_W(DW), .MAX_LOG2(4), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cntl       (cntl),
        .bus        (bus),
        .clip_count (clip_count),
        .flushing   (flushing)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          exp_q[$];
    int          hist[$];
    int          exp_clip = 0;
    logic [31:0] cur_cntl = '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int l_eff_of(input logic [31:0] c);
        int l;
        l = int'(c[4:2]);
        return (l > 4) ? 4 : l;
    endfunction

    // Reference: mean of the last 2^L enabled samples since the last flush
    // (missing ones count as zero), floored, scaled by 2^G, clamped to 16 bits.
    task automatic model_accept(input int x);
        int  n, s, avg, g, y;
        bit  clip;
        clip = 0;
        if (!cur_cntl[0]) begin
            y = x;
        end else begin
            n = 2 ** l_eff_of(cur_cntl);
            hist.push_back(x);
            if (hist.size() > 16) void'(hist.pop_front());
            s = 0;
            for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
            if (s >= 0) avg = s / n;
            else        avg = -((-s + n - 1) / n);
            g = avg * (2 ** int'(cur_cntl[8:5]));
            if (g > 32767) begin
                y = 32767; clip = 1;
            end else if (g < -32768) begin
                y = -32768; clip = 1;
            end else begin
                y = g;
            end
        end
        if (cur_cntl[9]) y = 0;
        if (clip && exp_clip < CLIP_M) exp_clip++;
        exp_q.push_back(y);
    endtask

    // Monitor: every valid&&ready cycle is one transfer to score.
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        int e;
        if (reset_n) begin
            if (prev_stall && bus.out_valid) chk("hold_stable", int'(bus.out_data), int'($signed(prev_data)));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_output", int'(bus.out_data), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(bus.out_data), e);
                end
            end
            if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", int'(bus.in_ready), 0);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input int x);
        bus.in_data  = DW'(x);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                model_accept(x);
                @(posedge clk);
                #1;
                return;
            end
        end
        fail("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            fail("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cntl(input logic [31:0] c, output int flush_cycles);
        if (c[1] || (l_eff_of(c) != l_eff_of(cur_cntl)) || (c[0] && !cur_cntl[0])) hist.delete();
        cur_cntl     = c;
        cntl         = c;
        flush_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (flushing) flush_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_burst(input int count);
        bit done;
        done = 0;
        fork
            begin
                for (int i = 0; i < count; i++) send(int'($urandom_range(0, 65535)) - 32768);
                idle();
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fc;
        int lowcnt;
        logic [31:0] c;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_clip", int'(clip_count), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_flushing", int'(flushing), 1);
        reset_n = 1'b1;

        // 1: L=0, G=0 pass-through with one-clock latency
        set_cntl(32'h1, fc);
        send(100);   chk("latency_1", int'(bus.out_valid), 1);
        send(-200);  chk("latency_2", int'(bus.out_valid), 1);
        send(32767); chk("latency_3", int'(bus.out_valid), 1);
        idle(); drain();
        chk("t1_clip", int'(clip_count), 0);

        // 2: L=2 ramp, then L=3 flush
        set_cntl(32'h9, fc);
        chk("t2_flush_l2", fc, 1);
        send(4); send(4); send(4); send(4); send(8);
        idle(); drain();
        set_cntl(32'hD, fc);
        chk("t2_flush_l3", fc, 1);
        send(8);
        idle(); drain();

        // 3: gain 16 saturation and clip counter saturation
        set_cntl(32'h81, fc);
        send(4096); idle(); drain();
        chk("t3_clip1", int'(clip_count), 1);
        send(-4096); idle(); drain();
        chk("t3_clip2", int'(clip_count), 2);
        for (int i = 0; i < 260; i++) send(4096);
        idle(); drain();
        chk("t3_clip_sat", int'(clip_count), CLIP_M);

        // 4: backpressure mid-stream
        set_cntl(32'h5, fc);
        fork
            begin
                for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 2000)) - 1000);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // 5: bypass, mute, clear held
        set_cntl(32'h0, fc);
        send(-5); idle(); drain();
        set_cntl(32'h201, fc);
        send(7); idle(); drain();
        c = 32'h201;
        hist.delete();
        cntl = c | 32'h2;
        lowcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!bus.in_ready) lowcnt++;
            @(posedge clk);
            #1;
            if (k == 2) cntl = c;
        end
        chk("t5_clear_stall", int'(lowcnt >= 3), 1);
        send(9); send(-9); idle(); drain();

        // 6: reset mid-stream with a pending output
        set_cntl(32'h1, fc);
        bus.out_ready = 1'b0;
        send(55); idle();
        @(negedge clk);
        chk("t6_pending", int'(bus.out_valid), 1);
        chk("t6_clip_before", int'(clip_count), exp_clip);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", int'(bus.out_valid), 0);
        chk("t6_rst_clip", int'(clip_count), 0);
        chk("t6_rst_in_ready", int'(bus.in_ready), 0);
        exp_q.delete();
        hist.delete();
        exp_clip = 0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        cur_cntl = 32'h0;
        set_cntl(32'h1, fc);
        send(100); send(-200); send(32767); idle(); drain();
        chk("t6_restart_clip", int'(clip_count), 0);

        // Randomized control settings and samples
        for (int r = 0; r < 30; r++) begin
            c = '0;
            c[0]   = ($urandom_range(0, 3) != 0);
            c[4:2] = 3'($urandom_range(0, 7));
            c[8:5] = 4'($urandom_range(0, 15));
            c[9]   = ($urandom_range(0, 3) == 0);
            c[31:10] = 22'($urandom);
            set_cntl(c, fc);
            random_burst(12);
        end
        chk("final_clip", int'(clip_count), exp_clip);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
